// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access, one transaction
// outstanding at a time; data wins ties unless a pending fetch has been starved too long.
module sram_like_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wen,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t             state_reg, state_next;
  logic               owner_reg, owner_next;   // 0 = inst, 1 = data
  logic [CNT_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic               wr_reg, wr_next;
  logic [1:0]         size_reg, size_next;
  logic [3:0]         wen_reg, wen_next;
  logic [31:0]        addr_reg, addr_next;
  logic [31:0]        wdata_reg, wdata_next;

  logic [1:0]         grant_v;                 // bit 0 = inst, bit 1 = data
  logic [1:0]         data_ok_v;
  logic [1:0][31:0]   rdata_v;
  logic               done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      starve_cnt_reg <= '0;
      wr_reg         <= 1'b0;
      size_reg       <= '0;
      wen_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
      wr_reg         <= wr_next;
      size_reg       <= size_next;
      wen_reg        <= wen_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  // Handshake pulses are gated by resetn so a held request never sees addr_ok during reset.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    starve_cnt_next = starve_cnt_reg;
    wr_next         = wr_reg;
    size_next       = size_reg;
    wen_next        = wen_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    grant_v         = 2'b00;
    done            = 1'b0;
    if (resetn) begin
      case (state_reg)
        IDLE: begin
          if (data_req && !(inst_req && starve_cnt_reg == LIMIT)) begin
            grant_v = 2'b10;
          end else if (inst_req) begin
            grant_v = 2'b01;
          end
          if (grant_v != 2'b00) begin
            state_next = REQ;
            owner_next = grant_v[1];
            wr_next    = grant_v[1] ? data_wr    : inst_wr;
            size_next  = grant_v[1] ? data_size  : inst_size;
            wen_next   = grant_v[1] ? data_wen   : inst_wen;
            addr_next  = grant_v[1] ? data_addr  : inst_addr;
            wdata_next = grant_v[1] ? data_wdata : inst_wdata;
            if (grant_v[1] && inst_req) begin
              starve_cnt_next = (starve_cnt_reg == LIMIT) ? LIMIT : starve_cnt_reg + 1'b1;
            end else begin
              starve_cnt_next = '0;
            end
          end
        end
        REQ: begin
          if (mem_addr_ok) begin
            if (mem_data_ok) begin
              done       = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = RESP;
            end
          end
        end
        RESP: begin
          if (mem_data_ok) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      assign data_ok_v[gi] = done && (owner_reg == 1'(gi));
      assign rdata_v[gi]   = data_ok_v[gi] ? mem_rdata : 32'd0;
    end
  endgenerate

  assign inst_addr_ok = grant_v[0];
  assign data_addr_ok = grant_v[1];
  assign inst_data_ok = data_ok_v[0];
  assign data_data_ok = data_ok_v[1];
  assign inst_rdata   = rdata_v[0];
  assign data_rdata   = rdata_v[1];

  assign mem_req   = (state_reg == REQ);
  assign mem_wr    = wr_reg;
  assign mem_size  = size_reg;
  assign mem_wen   = wen_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule
